// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- 8N1 asynchronous serial receiver, LSB first, idle-high line.
//
// Parameters:
//   BAUD       clock cycles per bit period (4 or more)
// Ports:
//   clk        single clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input
//   clr        acknowledge: clears valid, frame_err and overrun
//   data       last correctly framed byte
//   valid      data holds an unacknowledged byte
//   frame_err  sticky, a stop bit was sampled low
//   overrun    sticky, a byte completed while valid was still set
//   busy       receiver is not idle (combinational from the state register)

// Cycles per bit for 115200 baud from a 12 MHz clock, matching baudgen.vh.
`ifndef B115200
`define B115200 104
`endif

module uart_rx #(
  parameter int BAUD = `B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clr,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
  // IDLE loads the half-bit value so the start-bit sample lands mid-bit;
  // afterwards every sample is one full bit period after the previous one.
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD / 2);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic          sync1_q;
  logic          rxs_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  // Set while parked in STOP after a low stop bit, waiting for the line to
  // return high so a long break is not mistaken for a new start bit.
  logic          brk_q, brk_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    data_d  = data_q;
    // clr clears the flags unless a frame event below overrides them.
    valid_d = valid_q & ~clr;
    ferr_d  = ferr_q & ~clr;
    ovr_d   = ovr_q & ~clr;

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
          bit_d   = 3'd0;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = DATA;
            cnt_d   = FULL_LOAD;
          end else begin
            state_d = IDLE;  // glitch: no flag touched
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          // 3-bit index wraps 7->0 exactly on the move to STOP.
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      STOP: begin
        if (brk_q) begin
          if (rxs_q) begin
            state_d = IDLE;
            brk_d   = 1'b0;
          end
        end else if (cnt_q == '0) begin
          if (rxs_q) begin
            // A completion beats a simultaneous clr: valid set, overrun
            // only if the previous byte is still unacknowledged.
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = (ovr_q | valid_q) & ~clr;
            state_d = IDLE;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: one BAUD=16 instance (a) and one BAUD=5 instance (b).
// Inputs change 1 ns after a rising edge; outputs are read there too.
module tb_uart_rx;

  localparam int BA = 16;
  localparam int BB = 5;
  // rx pin edge -> valid edge: half bit + 9 bits + 2, plus 2 synchronizer cycles
  localparam int LAT_A = BA / 2 + 9 * BA + 2 + 2;
  localparam int LAT_B = BB / 2 + 9 * BB + 2 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, clr_a, rx_b, clr_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, ovr_a, busy_a;
  logic       valid_b, ferr_b, ovr_b, busy_b;

  uart_rx #(.BAUD(BA)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .clr(clr_a), .data(data_a),
    .valid(valid_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx #(.BAUD(BB)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .clr(clr_b), .data(data_b),
    .valid(valid_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_a = -1;
  int rise_b = -1;
  logic vprev_a = 1'b0;
  logic vprev_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle number of every valid rising edge.
  always @(negedge clk) begin
    if (valid_a && !vprev_a) rise_a <= cyc;
    if (valid_b && !vprev_b) rise_b <= cyc;
    vprev_a <= valid_a;
    vprev_b <= valid_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic chk_out(input bit sel, input string tag, input logic [7:0] d,
                         input logic v, input logic f, input logic o);
    if (sel) begin
      chk({tag, ".data"}, data_b, d);
      chk({tag, ".valid"}, valid_b, v);
      chk({tag, ".frame_err"}, ferr_b, f);
      chk({tag, ".overrun"}, ovr_b, o);
    end else begin
      chk({tag, ".data"}, data_a, d);
      chk({tag, ".valid"}, valid_a, v);
      chk({tag, ".frame_err"}, ferr_a, f);
      chk({tag, ".overrun"}, ovr_a, o);
    end
  endtask

  task automatic idle(input int n);
    rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one 8N1 frame then `tail` cycles at tail_lvl; clr is pulsed for
  // exactly one cycle at offset clr_off (negative: never).
  task automatic send(input bit sel, input int baud, input logic [7:0] b,
                      input bit stop, input int tail, input bit tail_lvl,
                      input int clr_off, output int start_cyc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    start_cyc = cyc;
    for (int c = 0; c < 10 * baud + tail; c++) begin
      logic r;
      r = (c < 10 * baud) ? fr[c / baud] : tail_lvl;
      if (sel) begin
        rx_b = r; clr_b = (c == clr_off);
      end else begin
        rx_a = r; clr_a = (c == clr_off);
      end
      @(posedge clk); #1;
    end
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask

  typedef enum {OP_FRAME, OP_CLR} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] b;
    bit         stop;
    int         tail;
    bit         lat;
    logic [7:0] ed;
    bit         ev, ef, eo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int s;
    logic [9:0] fr;
    logic [7:0] m_data;
    bit m_v, m_f, m_o;
    bit prev_bad;

    tbl[0] = '{OP_FRAME, 8'hA5, 1'b1, 0,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{OP_CLR,   8'h00, 1'b0, 0,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{OP_FRAME, 8'h3C, 1'b1, 0,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{OP_FRAME, 8'hC3, 1'b1, 0,  1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{OP_CLR,   8'h00, 1'b0, 0,  1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{OP_FRAME, 8'h00, 1'b0, BA, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{OP_FRAME, 8'h5A, 1'b1, 0,  1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{OP_FRAME, 8'h12, 1'b0, BA, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{OP_CLR,   8'h00, 1'b0, 0,  1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};

    // Reset, with rx low and clr high to show reset dominates both.
    rst = 1'b1; rx_a = 1'b0; clr_a = 1'b1; rx_b = 1'b1; clr_b = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk_out(0, "reset_a", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_a.busy", busy_a, 1'b0);
    chk("reset_b.busy", busy_b, 1'b0);
    rst = 1'b0; rx_a = 1'b1; clr_a = 1'b0;
    idle(4);
    chk("post_reset_a.busy", busy_a, 1'b0);

    // Table: single frames, back-to-back overrun, clr, framing errors.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].op == OP_CLR) begin
        pulse_clr_a();
      end else begin
        send(0, BA, tbl[i].b, tbl[i].stop, tbl[i].tail, 1'b1, -1, s);
        if (tbl[i].lat) chk($sformatf("vec%0d.latency", i), rise_a - s, LAT_A);
      end
      chk_out(0, $sformatf("vec%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].ef, tbl[i].eo);
    end

    // Break: bad stop bit, then line held low for 40 more cycles.
    send(0, BA, 8'h0F, 1'b0, 40, 1'b0, -1, s);
    chk_out(0, "break_low", 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("break_low.busy", busy_a, 1'b1);
    idle(6);
    chk("break_end.busy", busy_a, 1'b0);
    send(0, BA, 8'h55, 1'b1, 0, 1'b1, -1, s);
    chk_out(0, "after_break", 8'h55, 1'b1, 1'b1, 1'b0);

    // Glitch: 4 low cycles only.
    rx_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("glitch.busy_high", busy_a, 1'b1);
    idle(16);
    chk("glitch.busy_low", busy_a, 1'b0);
    chk_out(0, "glitch", 8'h55, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of data bit 4, then a clean 8'h81.
    fr = {1'b1, 8'hF0, 1'b0};
    for (int c = 0; c < 5 * BA + 8; c++) begin
      rx_a = fr[c / BA];
      @(posedge clk); #1;
    end
    rst = 1'b1; rx_a = 1'b1; clr_a = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; clr_a = 1'b0;
    idle(4);
    chk_out(0, "abort", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("abort.busy", busy_a, 1'b0);
    send(0, BA, 8'h81, 1'b1, 0, 1'b1, -1, s);
    chk("rx81.latency", rise_a - s, LAT_A);
    chk_out(0, "rx81", 8'h81, 1'b1, 1'b0, 1'b0);

    // clr exactly on the completion cycle of 8'hFF while valid is set.
    send(0, BA, 8'hFF, 1'b1, 0, 1'b1, LAT_A - 1, s);
    chk_out(0, "clr_coinc_a", 8'hFF, 1'b1, 1'b0, 1'b0);

    send(1, BB, 8'h11, 1'b1, BB, 1'b1, -1, s);
    chk("b11.latency", rise_b - s, LAT_B);
    chk_out(1, "b11", 8'h11, 1'b1, 1'b0, 1'b0);
    send(1, BB, 8'hFF, 1'b1, BB, 1'b1, LAT_B - 1, s);
    chk_out(1, "clr_coinc_b", 8'hFF, 1'b1, 1'b0, 1'b0);

    // Random frames against a flag-level reference model.
    m_data = 8'hFF; m_v = 1'b1; m_f = 1'b0; m_o = 1'b0;
    prev_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      int gap, clr_off;
      logic [7:0] b;
      bit stop, clr_before, clr_after;
      gap = prev_bad ? $urandom_range(1, 2) : $urandom_range(0, 2);
      if (gap > 0) idle(gap * BA);
      b = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      clr_off = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10 * BA - 1) : -1;
      send(0, BA, b, stop, 0, 1'b1, clr_off, s);
      // clr affects the edge after its cycle; the frame event is at edge LAT_A.
      clr_before = (clr_off >= 0) && (clr_off + 1 <= LAT_A);
      clr_after  = (clr_off >= 0) && !clr_before;
      if (clr_before) begin m_v = 0; m_f = 0; m_o = 0; end
      if (stop) begin
        m_o = m_o | m_v; m_v = 1'b1; m_data = b;
      end else begin
        m_f = 1'b1;
      end
      if (clr_after) begin m_v = 0; m_f = 0; m_o = 0; end
      prev_bad = !stop;
      chk_out(0, $sformatf("rnd%0d(%02h,stop=%0d,clr=%0d)", k, b, stop, clr_off),
              m_data, m_v, m_f, m_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default `B115200 from baudgen.vh, meaning clock cycles per bit period; legal range is 4 or greater.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1 format, LSB first, idle high.
REQ-005 SHALL have port clr, input, 1 bit: acknowledge; clears valid, frame_err and overrun.
REQ-006 SHALL have port data, output, 8 bits: last correctly framed received byte.
REQ-007 SHALL have port valid, output, 1 bit: data holds an unacknowledged byte.
REQ-008 SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-009 SHALL have port overrun, output, 1 bit: sticky flag, byte completed while valid was already set.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; "rxs" below means the second flop output, and both flops reset to 1.
REQ-012 SHALL implement exactly four states: IDLE, START, DATA, STOP; any illegal encoding SHALL go to IDLE on the next cycle.
REQ-013 SHALL hold a cycle counter and a 3-bit bit index; the bit index wraps 7->0 only on the DATA->STOP transition.
REQ-014 In IDLE, rxs=0 for one cycle SHALL move the block to START and load the cycle counter so the next sample falls BAUD/2 cycles later (integer divide).
REQ-015 At the START sample: if rxs=0, the block SHALL move to DATA; if rxs=1, it SHALL treat this as a glitch, return to IDLE, and change no flag.
REQ-016 In DATA, rxs SHALL be sampled every BAUD cycles, 8 samples in total, shifted in LSB first; after the 8th sample the block SHALL move to STOP.
REQ-017 The STOP sample SHALL fall BAUD cycles after the 8th data sample.
REQ-018 At the STOP sample with rxs=1, the next cycle SHALL give: data = assembled byte, valid=1, and overrun=1 if valid was 1 and clr was 0 on the sample cycle; then IDLE.
REQ-019 At the STOP sample with rxs=0: data and valid SHALL be unchanged and frame_err=1; the block SHALL stay in STOP until rxs=1, then go to IDLE (break tolerance, no false start).
REQ-020 clr=1 SHALL clear valid, frame_err and overrun on the next cycle; data SHALL remain unchanged.
REQ-021 If clr coincides with a byte completion, the completion SHALL win: valid=1, overrun=0, frame_err cleared.
REQ-022 If clr coincides with a framing error, frame_err SHALL be 1.
REQ-023 Latency from the rxs falling edge to the valid rise SHALL be BAUD/2 + 9*BAUD + 2 cycles, plus 2 cycles of synchronizer delay from the rx pin.
REQ-024 Back-to-back frames SHALL be received with zero idle bits between them: IDLE sees the next start bit during the second half of the stop bit.
REQ-025 busy SHALL be combinational from the state register; all other outputs SHALL be registered.

Reset
REQ-026 On rst=1, the state SHALL be IDLE, the counters 0, the synchronizer flops 1, data=8'h00, and valid, frame_err, overrun and busy 0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no flag set, and reception SHALL resume on the next falling edge after rst deasserts.
REQ-028 rst SHALL take priority over clr and over rx activity.

Verification (BAUD=16 unless stated)
REQ-029 Send byte 8'hA5 at 16 clk/bit -> valid=1 and data=8'hA5 exactly at the REQ-023 latency; frame_err=0, overrun=0.
REQ-030 Send 8'h3C then 8'hC3 back-to-back with no clr between them -> data=8'hC3, valid=1, overrun=1; clr -> all flags 0, data stays 8'hC3.
REQ-031 Pulse rx low for 4 cycles only -> busy rises then falls; valid, frame_err and data unchanged.
REQ-032 Send a frame with stop bit 0, then hold rx low for 40 cycles -> frame_err=1, valid=0, busy=1 until rx goes high; then a normal byte 8'h55 -> data=8'h55, valid=1.
REQ-033 Assert rst during data bit 4 of a frame, then send 8'h81 -> the aborted frame produces nothing; 8'h81 is received cleanly.
REQ-034 Hold clr=1 on the valid-rise cycle of 8'hFF -> valid=1, overrun=0, data=8'hFF; repeat with BAUD=5 -> same result.
